mem_port_ctrl: RTL and testbench

Single-port memory access controller placed between the multicycle MIPS datapath and the unified instruction/data memory. It accepts instruction-fetch and load/store requests and arbitrates between them, with data taking priority. It computes the effective address and drives the memory's address, write-data and write-enable inputs. It captures the memory's combinational read data into result registers and returns it with a one-cycle done pulse. Out-of-range addresses are reported as faults, and no memory access is made for them.

---
 rtl/mem_port_ctrl_if.sv | 31 +++
 rtl/mem_port_ctrl.sv | 112 +++++++++++
 tb/tb_mem_port_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_ctrl_if.sv
// Request/response bundle between the multicycle datapath and mem_port_ctrl.
interface mem_port_ctrl_if;
  // fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_instr;
  // load/store side
  logic        d_req;
  logic        d_we;
  logic [31:0] d_base;
  logic [15:0] d_offset;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  // status
  logic        fault;
  logic        busy;

  // datapath side issues requests and consumes results
  modport master (
    output if_req, if_addr, d_req, d_we, d_base, d_offset, d_wdata,
    input  if_done, if_instr, d_done, d_rdata, fault, busy
  );

  // controller side serves requests and returns results
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_base, d_offset, d_wdata,
    output if_done, if_instr, d_done, d_rdata, fault, busy
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Single-port memory controller: arbitrates fetch vs load/store (data first),
// range-checks the address, drives the memory and returns results with a done pulse.
module mem_port_ctrl #(
  parameter int unsigned MAX_ADDR = 512
) (
  input  logic        Clk,
  input  logic        Rst_n,
  mem_port_ctrl_if.slave bus,
  output logic [31:0] Address,
  output logic [31:0] writeData,
  output logic        writeEnable,
  input  logic [31:0] MemData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic        is_data;   // request in flight is load/store, not fetch
  logic        is_store;  // request in flight is a store
  logic        legal;     // latched address passed the range check

  logic [31:0] eff_addr_c;
  logic        d_legal_c;
  logic        if_legal_c;

  // Effective address (wraps mod 2^32) and range checks for both requesters
  always_comb begin
    eff_addr_c = bus.d_base + {{16{bus.d_offset[15]}}, bus.d_offset};
    d_legal_c  = (eff_addr_c <= 32'(MAX_ADDR));
    if_legal_c = (bus.if_addr <= 32'(MAX_ADDR));
  end

  // Controller FSM with registered memory-side and result outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      is_data      <= 1'b0;
      is_store     <= 1'b0;
      legal        <= 1'b0;
      Address      <= 32'd0;
      writeData    <= 32'd0;
      writeEnable  <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.if_instr <= 32'd0;
      bus.d_done   <= 1'b0;
      bus.d_rdata  <= 32'd0;
      bus.fault    <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_req) begin
            state    <= ACCESS;
            bus.busy <= 1'b1;
            is_data  <= 1'b1;
            is_store <= bus.d_we;
            legal    <= d_legal_c;
            // illegal addresses leave the memory port untouched
            if (d_legal_c) begin
              Address <= eff_addr_c;
              if (bus.d_we) begin
                writeData   <= bus.d_wdata;
                writeEnable <= 1'b1;
              end
            end
          end else if (bus.if_req) begin
            state    <= ACCESS;
            bus.busy <= 1'b1;
            is_data  <= 1'b0;
            is_store <= 1'b0;
            legal    <= if_legal_c;
            if (if_legal_c) begin
              Address <= bus.if_addr;
            end
          end
        end

        ACCESS: begin
          state       <= DONE;
          writeEnable <= 1'b0;
          bus.fault   <= ~legal;
          if (is_data) begin
            bus.d_done <= 1'b1;
            if (!is_store) begin
              bus.d_rdata <= legal ? MemData : 32'd0;
            end
          end else begin
            bus.if_done  <= 1'b1;
            bus.if_instr <= legal ? MemData : 32'd0;
          end
        end

        DONE: begin
          state       <= IDLE;
          bus.d_done  <= 1'b0;
          bus.if_done <= 1'b0;
          bus.fault   <= 1'b0;
          bus.busy    <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural word memory.
module tb_mem_port_ctrl;
  localparam int unsigned MAX_ADDR = 512;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Address;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [31:0] MemData;
  logic        init_en;

  int total;
  int bad;

  mem_port_ctrl_if bus ();

  mem_port_ctrl #(.MAX_ADDR(MAX_ADDR)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .bus         (bus),
    .Address     (Address),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .MemData     (MemData)
  );

  always #5 Clk = ~Clk;

  // Memory model: combinational read, write on rising edge, preload while init_en
  logic [31:0] mem [0:MAX_ADDR];

  always_comb begin
    MemData = 32'd0;
    if (Address <= 32'(MAX_ADDR)) MemData = mem[Address[9:0]];
  end

  always @(posedge Clk) begin
    if (init_en) begin
      for (int i = 0; i <= int'(MAX_ADDR); i++) mem[i] <= 32'd0;
      mem[1]   <= 32'd1;
      mem[2]   <= 32'h1234_5678;
      mem[128] <= 32'h8C03_0000;
      mem[512] <= 32'h5A5A_0200;
    end else if (writeEnable && (Address <= 32'(MAX_ADDR))) begin
      mem[Address[9:0]] <= writeData;
    end
  end

  task automatic test_reset();
    Rst_n   = 1'b0;
    init_en = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      bus.if_req   = 1'($urandom);
      bus.if_addr  = $urandom;
      bus.d_req    = 1'($urandom);
      bus.d_we     = 1'($urandom);
      bus.d_base   = $urandom;
      bus.d_offset = 16'($urandom);
      bus.d_wdata  = $urandom;
    end
    @(negedge Clk);
    total++; if ({bus.if_done, bus.d_done, bus.fault, bus.busy, writeEnable} !== 5'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=00000", {bus.if_done, bus.d_done, bus.fault, bus.busy, writeEnable}); end
    total++; if (Address !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", Address); end
    total++; if (writeData !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", writeData); end
    total++; if ({bus.d_rdata, bus.if_instr} !== 64'd0) begin
      bad++; $display("FAIL rst_results got=%h exp=0", {bus.d_rdata, bus.if_instr}); end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    init_en = 1'b0;
    Rst_n   = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if ({bus.if_done, bus.d_done, bus.fault, bus.busy, writeEnable} !== 5'b0) begin
      bad++; $display("FAIL post_rst_flags got=%b exp=00000", {bus.if_done, bus.d_done, bus.fault, bus.busy, writeEnable}); end
    total++; if (Address !== 32'd0) begin bad++; $display("FAIL post_rst_addr got=%h exp=0", Address); end
  endtask

  task automatic test_load();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_base = 32'd0; bus.d_offset = 16'd1;
    @(negedge Clk);  // ACCESS
    total++; if (Address !== 32'd1) begin bad++; $display("FAIL load_addr got=%h exp=1", Address); end
    total++; if ({bus.busy, writeEnable, bus.d_done} !== 3'b100) begin
      bad++; $display("FAIL load_access_flags got=%b exp=100", {bus.busy, writeEnable, bus.d_done}); end
    @(negedge Clk);  // DONE
    total++; if ({bus.d_done, bus.if_done, bus.fault} !== 3'b100) begin
      bad++; $display("FAIL load_done got=%b exp=100", {bus.d_done, bus.if_done, bus.fault}); end
    total++; if (bus.d_rdata !== 32'd1) begin bad++; $display("FAIL load_rdata got=%h exp=1", bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);  // IDLE
    total++; if ({bus.d_done, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL load_idle got=%b exp=00", {bus.d_done, bus.busy}); end
  endtask

  task automatic test_store_neg_offset();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_base = 32'd8; bus.d_offset = 16'hFFFF;
    bus.d_wdata = 32'hAC04_0006;
    @(negedge Clk);  // ACCESS
    total++; if (Address !== 32'd7) begin bad++; $display("FAIL st_addr got=%h exp=7", Address); end
    total++; if (writeEnable !== 1'b1) begin bad++; $display("FAIL st_we_access got=%b exp=1", writeEnable); end
    total++; if (writeData !== 32'hAC04_0006) begin bad++; $display("FAIL st_wdata got=%h exp=ac040006", writeData); end
    @(negedge Clk);  // DONE
    total++; if ({bus.d_done, bus.fault, writeEnable} !== 3'b100) begin
      bad++; $display("FAIL st_done got=%b exp=100", {bus.d_done, bus.fault, writeEnable}); end
    total++; if (mem[7] !== 32'hAC04_0006) begin bad++; $display("FAIL st_mem7 got=%h exp=ac040006", mem[7]); end
    total++; if (bus.d_rdata !== 32'd1) begin bad++; $display("FAIL st_rdata_kept got=%h exp=1", bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);
    total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL st_we_idle got=%b exp=0", writeEnable); end
  endtask

  task automatic test_arbitration();
    bus.if_req = 1'b1; bus.if_addr = 32'd128;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_base = 32'd2; bus.d_offset = 16'd0;
    @(negedge Clk);  // +1 ACCESS (data)
    total++; if (Address !== 32'd2) begin bad++; $display("FAIL arb_data_addr got=%h exp=2", Address); end
    @(negedge Clk);  // +2 DONE (data)
    total++; if ({bus.d_done, bus.if_done} !== 2'b10) begin
      bad++; $display("FAIL arb_data_done got=%b exp=10", {bus.d_done, bus.if_done}); end
    total++; if (bus.d_rdata !== 32'h1234_5678) begin bad++; $display("FAIL arb_rdata got=%h exp=12345678", bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);  // +3 IDLE, fetch accepted at the next edge
    total++; if ({bus.busy, bus.if_done} !== 2'b00) begin
      bad++; $display("FAIL arb_idle got=%b exp=00", {bus.busy, bus.if_done}); end
    @(negedge Clk);  // +4 ACCESS (fetch)
    total++; if (Address !== 32'd128) begin bad++; $display("FAIL arb_fetch_addr got=%h exp=80", Address); end
    @(negedge Clk);  // +5 DONE (fetch)
    total++; if ({bus.if_done, bus.d_done, bus.fault} !== 3'b100) begin
      bad++; $display("FAIL arb_fetch_done got=%b exp=100", {bus.if_done, bus.d_done, bus.fault}); end
    total++; if (bus.if_instr !== 32'h8C03_0000) begin bad++; $display("FAIL arb_instr got=%h exp=8c030000", bus.if_instr); end
    bus.if_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_fault();
    // store to 0x200+1 = 513: out of range, memory port stays idle
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_base = 32'h200; bus.d_offset = 16'd1;
    bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge Clk);  // ACCESS
    total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL flt_st_we got=%b exp=0", writeEnable); end
    total++; if (Address !== 32'd128) begin bad++; $display("FAIL flt_st_addr_held got=%h exp=80", Address); end
    total++; if (writeData !== 32'hAC04_0006) begin bad++; $display("FAIL flt_st_wdata_held got=%h exp=ac040006", writeData); end
    @(negedge Clk);  // DONE
    total++; if ({bus.d_done, bus.fault, writeEnable} !== 3'b110) begin
      bad++; $display("FAIL flt_st_done got=%b exp=110", {bus.d_done, bus.fault, writeEnable}); end
    total++; if (mem[1] !== 32'd1) begin bad++; $display("FAIL flt_st_mem1 got=%h exp=1", mem[1]); end
    total++; if (bus.d_rdata !== 32'h1234_5678) begin bad++; $display("FAIL flt_st_rdata_kept got=%h exp=12345678", bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL flt_cleared got=%b exp=0", bus.fault); end
    // load from the same illegal address returns zero
    bus.d_req = 1'b1; bus.d_we = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if ({bus.d_done, bus.fault} !== 2'b11) begin
      bad++; $display("FAIL flt_ld_done got=%b exp=11", {bus.d_done, bus.fault}); end
    total++; if (bus.d_rdata !== 32'd0) begin bad++; $display("FAIL flt_ld_rdata got=%h exp=0", bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);
    // fetch from an illegal PC
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
    repeat (2) @(negedge Clk);
    total++; if ({bus.if_done, bus.fault} !== 2'b11) begin
      bad++; $display("FAIL flt_if_done got=%b exp=11", {bus.if_done, bus.fault}); end
    total++; if (bus.if_instr !== 32'd0) begin bad++; $display("FAIL flt_if_instr got=%h exp=0", bus.if_instr); end
    bus.if_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_boundary();
    // 510 + 2 = 512 is the last legal word
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_base = 32'd510; bus.d_offset = 16'd2;
    repeat (2) @(negedge Clk);
    total++; if ({bus.d_done, bus.fault} !== 2'b10) begin
      bad++; $display("FAIL bnd_max_done got=%b exp=10", {bus.d_done, bus.fault}); end
    total++; if (bus.d_rdata !== 32'h5A5A_0200) begin bad++; $display("FAIL bnd_max_rdata got=%h exp=5a5a0200", bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);
    // 0xFFFFFFFF + 3 wraps to 2
    bus.d_req = 1'b1; bus.d_base = 32'hFFFF_FFFF; bus.d_offset = 16'd3;
    @(negedge Clk);
    total++; if (Address !== 32'd2) begin bad++; $display("FAIL bnd_wrap_addr got=%h exp=2", Address); end
    @(negedge Clk);
    total++; if ({bus.d_done, bus.fault} !== 2'b10 || bus.d_rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL bnd_wrap_rdata got=%b/%h exp=10/12345678", {bus.d_done, bus.fault}, bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_access();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_base = 32'd0; bus.d_offset = 16'd9;
    bus.d_wdata = 32'h1111_2222;
    @(negedge Clk);  // ACCESS
    total++; if (writeEnable !== 1'b1) begin bad++; $display("FAIL mid_we_before got=%b exp=1", writeEnable); end
    #1 Rst_n = 1'b0;
    #1;
    total++; if ({writeEnable, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL mid_we_drop got=%b exp=00", {writeEnable, bus.busy}); end
    @(negedge Clk);
    total++; if (mem[9] !== 32'd0) begin bad++; $display("FAIL mid_mem9 got=%h exp=0", mem[9]); end
    total++; if (bus.d_done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b exp=0", bus.d_done); end
    bus.d_req = 1'b0;
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if ({bus.d_done, bus.busy, writeEnable} !== 3'b000 || mem[9] !== 32'd0) begin
      bad++; $display("FAIL mid_after got=%b/%h exp=000/0", {bus.d_done, bus.busy, writeEnable}, mem[9]); end
    // controller is back in IDLE and serves a load of word 7
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_base = 32'd7; bus.d_offset = 16'd0;
    repeat (2) @(negedge Clk);
    total++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'hAC04_0006) begin
      bad++; $display("FAIL mid_reload got=%b/%h exp=1/ac040006", bus.d_done, bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst_n = 1'b0;
    init_en = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_base = 32'd0;
    bus.d_offset = 16'd0; bus.d_wdata = 32'd0;
    test_reset();
    test_load();
    test_store_neg_offset();
    test_arbitration();
    test_fault();
    test_boundary();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
